// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares a single-port data memory between two requesters:
//   port 0 : pipeline MEM stage
//   port 1 : loader / debug DMA
//
// Grants are combinational and round-robin. A write lands at the same rising
// edge as its grant. A read returns registered data one cycle after its grant.
//
// A granted port may hold the memory across transactions by keeping lockN
// high. A lock is held for at most LOCK_MAX cycles. When a lock times out:
//   - the port is forced off,
//   - lock_err pulses for one cycle,
//   - the port may not relock until it drops lockN once.
//
// Optional feature (macro DMEM_ARB_PERF_EN): when defined, the block adds
// 32-bit counters gnt_cnt0, gnt_cnt1 and stall_cnt. The counters wrap.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   req0/1, we0/1, lock0/1        request, write enable, lock request
//   addr0/1, wdata0/1             word address and write data per port
//   gnt0/1                        combinational grant
//   rvalid0/1, rdata0/1           registered read response per port
//   lock_err                      one-cycle pulse on lock timeout
//   mem_we, mem_addr, mem_wdata   to memory
//   mem_rdata                     from memory (combinational read)
//   gnt_cnt0/1, stall_cnt         perf counters (DMEM_ARB_PERF_EN only)
// -----------------------------------------------------------------------------
module dmem_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int LOCK_MAX = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic              lock0,
   input  logic              lock1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              lock_err,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
   ,
   output logic [31:0]       gnt_cnt0,
   output logic [31:0]       gnt_cnt1,
   output logic [31:0]       stall_cnt
`endif
);

   localparam int CNT_W = $clog2(LOCK_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {
      ARB   = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } state_t;

   state_t           state_reg, state_next;
   logic             last_gnt_reg, last_gnt_next;
   logic [CNT_W-1:0] lock_cnt_reg, lock_cnt_next;
   logic [1:0]       blk_reg, blk_next;
   logic             lock_err_reg, lock_err_next;

   // Per-port views so the response path can be generated for both ports.
   logic [1:0]        req_v, we_v, lock_v, gnt_v;
   logic [DATA_W-1:0] rdata_v [2];
   logic [1:0]        rvalid_v;

   assign req_v  = {req1, req0};
   assign we_v   = {we1, we0};
   assign lock_v = {lock1, lock0};

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= ARB;
         last_gnt_reg <= 1'b1;   // port 0 wins the first conflict
         lock_cnt_reg <= '0;
         blk_reg      <= 2'b00;
         lock_err_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         last_gnt_reg <= last_gnt_next;
         lock_cnt_reg <= lock_cnt_next;
         blk_reg      <= blk_next;
         lock_err_reg <= lock_err_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      last_gnt_next = last_gnt_reg;
      lock_cnt_next = lock_cnt_reg;
      // A block flag clears as soon as its port lets go of lock.
      blk_next      = blk_reg & lock_v;
      lock_err_next = 1'b0;
      gnt_v         = 2'b00;

      case (state_reg)
         ARB: begin
            if (req_v == 2'b11)
               gnt_v = last_gnt_reg ? 2'b01 : 2'b10;
            else
               gnt_v = req_v;

            if (gnt_v[0] && lock_v[0] && !blk_reg[0]) begin
               state_next    = LOCK0;
               lock_cnt_next = CNT_ONE;
            end else if (gnt_v[1] && lock_v[1] && !blk_reg[1]) begin
               state_next    = LOCK1;
               lock_cnt_next = CNT_ONE;
            end
         end

         LOCK0: begin
            // The other port stalls even when the owner is idle.
            gnt_v[0] = req_v[0];
            if (!lock_v[0]) begin
               state_next    = ARB;
               lock_cnt_next = '0;
            end else if (lock_cnt_reg == CNT_MAX) begin
               state_next    = ARB;
               lock_cnt_next = '0;
               lock_err_next = 1'b1;
               blk_next[0]   = 1'b1;
            end else begin
               lock_cnt_next = lock_cnt_reg + CNT_ONE;
            end
         end

         LOCK1: begin
            gnt_v[1] = req_v[1];
            if (!lock_v[1]) begin
               state_next    = ARB;
               lock_cnt_next = '0;
            end else if (lock_cnt_reg == CNT_MAX) begin
               state_next    = ARB;
               lock_cnt_next = '0;
               lock_err_next = 1'b1;
               blk_next[1]   = 1'b1;
            end else begin
               lock_cnt_next = lock_cnt_reg + CNT_ONE;
            end
         end

         default: state_next = ARB;
      endcase

      // No transaction is accepted while reset is high, so no write can
      // reach memory during reset.
      if (reset)
         gnt_v = 2'b00;

      if (gnt_v[0])
         last_gnt_next = 1'b0;
      else if (gnt_v[1])
         last_gnt_next = 1'b1;
   end

   assign gnt0     = gnt_v[0];
   assign gnt1     = gnt_v[1];
   assign lock_err = lock_err_reg;

   // ------------------------------------------------------- memory mux
   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (gnt_v[0]) begin
         mem_we    = we0;
         mem_addr  = addr0;
         mem_wdata = wdata0;
      end else if (gnt_v[1]) begin
         mem_we    = we1;
         mem_addr  = addr1;
         mem_wdata = wdata1;
      end
   end

   // -------------------------------------------------- read responses
   for (genvar gi = 0; gi < 2; gi++) begin : g_resp
      logic              rvalid_reg;
      logic [DATA_W-1:0] rdata_reg;

      always_ff @(posedge clk) begin
         if (reset) begin
            rvalid_reg <= 1'b0;
            rdata_reg  <= '0;
         end else begin
            rvalid_reg <= gnt_v[gi] & ~we_v[gi];
            if (gnt_v[gi] && !we_v[gi])
               rdata_reg <= mem_rdata;
         end
      end

      assign rvalid_v[gi] = rvalid_reg;
      assign rdata_v[gi]  = rdata_reg;
   end

   assign rvalid0 = rvalid_v[0];
   assign rvalid1 = rvalid_v[1];
   assign rdata0  = rdata_v[0];
   assign rdata1  = rdata_v[1];

`ifdef DMEM_ARB_PERF_EN
   // ------------------------------------------------- perf counters
   logic stall;
   // A cycle counts once as a stall even if both ports are waiting.
   assign stall = |(req_v & ~gnt_v);

   always_ff @(posedge clk) begin
      if (reset) begin
         gnt_cnt0  <= '0;
         gnt_cnt1  <= '0;
         stall_cnt <= '0;
      end else begin
         if (gnt_v[0]) gnt_cnt0  <= gnt_cnt0 + 32'd1;
         if (gnt_v[1]) gnt_cnt1  <= gnt_cnt1 + 32'd1;
         if (stall)    stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Drives directed scenarios followed by randomized traffic into dmem_arbiter.
// A transaction-level reference model predicts the outputs cycle by cycle.
// The model tracks:
//   - the lock owner (or none),
//   - the lock cycle count,
//   - the last grant,
//   - the block flags,
//   - a shadow memory.
//
// The bench also owns the behavioural data memory that the DUT drives.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;
   localparam int LM = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0, req1, we0, we1, lock0, lock1;
   logic [31:0] addr0, addr1, wdata0, wdata1;
   logic        gnt0, gnt1, rvalid0, rvalid1, lock_err;
   logic [31:0] rdata0, rdata1;
   logic        mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_PERF_EN
   logic [31:0] gnt_cnt0, gnt_cnt1, stall_cnt;
`endif

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .LOCK_MAX(LM)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .lock0(lock0), .lock1(lock1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata0(rdata0), .rdata1(rdata1), .lock_err(lock_err),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_PERF_EN
      , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1), .stall_cnt(stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Behavioural data memory: combinational read, write at the clock edge.
   logic [31:0] mem [16] = '{default: 32'd0};
   assign mem_rdata = mem[mem_addr[3:0]];
   always @(posedge clk) if (mem_we) mem[mem_addr[3:0]] <= mem_wdata;

   // Reference model state, starting at the post-reset values.
   int          own     = -1;   // lock owner, -1 when arbitrating freely
   int          cnt     = 0;
   int          last    = 1;
   bit          blk [2] = '{1'b0, 1'b0};
   bit          exp_rv [2] = '{1'b0, 1'b0};
   logic [31:0] exp_rd [2] = '{32'd0, 32'd0};
   bit          exp_err = 1'b0;
   logic [31:0] ref_mem [16] = '{default: 32'd0};
   logic [31:0] exp_gc [2] = '{32'd0, 32'd0};
   logic [31:0] exp_stall = 32'd0;

   int checks = 0;
   int errors = 0;
   bit lk0 = 1'b0, lk1 = 1'b0;
   int err_seen;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle:
   //   1. Check the DUT against the model at the falling edge.
   //   2. Advance the model.
   //   3. Return just after the rising edge.
   task automatic cycle();
      int          g;
      bit          r [2], w [2], l [2];
      logic [31:0] a [2], d [2];
      bit          new_err;
      @(negedge clk);
      r = '{req0, req1}; w = '{we0, we1}; l = '{lock0, lock1};
      a = '{addr0, addr1}; d = '{wdata0, wdata1};

      g = -1;
      if (!reset) begin
         if (own >= 0) begin
            if (r[own]) g = own;
         end else if (r[0] && r[1]) g = 1 - last;
         else if (r[0]) g = 0;
         else if (r[1]) g = 1;
      end

      chk1("gnt0", gnt0, g == 0);
      chk1("gnt1", gnt1, g == 1);
      chk1("mem_we", mem_we, (g >= 0) ? w[g] : 1'b0);
      chk32("mem_addr", mem_addr, (g >= 0) ? a[g] : 32'd0);
      chk32("mem_wdata", mem_wdata, (g >= 0) ? d[g] : 32'd0);
      chk1("rvalid0", rvalid0, exp_rv[0]);
      chk1("rvalid1", rvalid1, exp_rv[1]);
      chk32("rdata0", rdata0, exp_rd[0]);
      chk32("rdata1", rdata1, exp_rd[1]);
      chk1("lock_err", lock_err, exp_err);
`ifdef DMEM_ARB_PERF_EN
      chk32("gnt_cnt0", gnt_cnt0, exp_gc[0]);
      chk32("gnt_cnt1", gnt_cnt1, exp_gc[1]);
      chk32("stall_cnt", stall_cnt, exp_stall);
`endif

      if (reset) begin
         own = -1; cnt = 0; last = 1; blk = '{1'b0, 1'b0};
         exp_rv = '{1'b0, 1'b0}; exp_rd = '{32'd0, 32'd0}; exp_err = 1'b0;
         exp_gc = '{32'd0, 32'd0}; exp_stall = 32'd0;
      end else begin
         new_err = 1'b0;
         for (int k = 0; k < 2; k++) begin
            exp_rv[k] = (g == k) && !w[k];
            if (exp_rv[k]) exp_rd[k] = ref_mem[a[k][3:0]];
         end
         if (g >= 0 && w[g]) ref_mem[a[g][3:0]] = d[g];
         if (g >= 0) last = g;
         if (own >= 0) begin
            if (!l[own]) own = -1;
            else if (cnt == LM) begin
               blk[own] = 1'b1; own = -1; new_err = 1'b1;
            end else cnt++;
         end else if (g >= 0 && l[g] && !blk[g]) begin
            own = g; cnt = 1;
         end
         for (int k = 0; k < 2; k++) if (!l[k]) blk[k] = 1'b0;
         exp_err = new_err;
         if (g >= 0) exp_gc[g] = exp_gc[g] + 32'd1;
         if ((r[0] && g != 0) || (r[1] && g != 1)) exp_stall = exp_stall + 32'd1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit r0, input bit w0, input bit l0,
                        input logic [31:0] a0, input logic [31:0] d0,
                        input bit r1, input bit w1, input bit l1,
                        input logic [31:0] a1, input logic [31:0] d1);
      req0 = r0; we0 = w0; lock0 = l0; addr0 = a0; wdata0 = d0;
      req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
      cycle();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
      addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Scenario 1: write then read back on port 0.
      drive(1, 1, 0, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 5, 0, 0, 0, 0, 0, 0);
      chk1("t1_rvalid0", rvalid0, 1'b1);
      chk32("t1_rdata0", rdata0, 32'hDEADBEEF);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Scenario 2: both ports read for 4 cycles.
      do_reset();
      for (int i = 0; i < 4; i++) drive(1, 0, 0, 5, 0, 1, 0, 0, 7, 0);
`ifdef DMEM_ARB_PERF_EN
      chk32("t6_gnt_cnt0", gnt_cnt0, 32'd2);
      chk32("t6_gnt_cnt1", gnt_cnt1, 32'd2);
      chk32("t6_stall_cnt", stall_cnt, 32'd4);
`endif
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Scenario 3: port 1 takes and releases a lock while port 0 waits.
      do_reset();
      drive(0, 0, 0, 0, 0, 1, 1, 1, 2, 32'h11);
      drive(1, 0, 0, 3, 0, 1, 1, 1, 2, 32'h22);
      drive(1, 0, 0, 3, 0, 1, 0, 1, 2, 0);
      drive(1, 0, 0, 3, 0, 1, 1, 0, 4, 32'h33);
      drive(1, 0, 0, 3, 0, 1, 0, 0, 4, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Scenario 4: port 0 holds a lock until it times out.
      do_reset();
      err_seen = 0;
      for (int i = 0; i < 9; i++) begin
         drive(1, 0, 1, 6, 0, 1, 0, 0, 8, 0);
         if (lock_err) err_seen++;
      end
      chk32("t4_lock_err_pulses", err_seen, 32'd1);
      drive(1, 0, 0, 6, 0, 1, 0, 0, 8, 0);
      for (int i = 0; i < 3; i++) drive(1, 0, 1, 6, 0, 1, 0, 0, 8, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Scenario 5: reset lands while a port 1 read is in flight.
      do_reset();
      drive(0, 0, 0, 0, 0, 1, 0, 0, 5, 0);
      reset = 1'b1;
      drive(1, 1, 1, 9, 32'h5A5A, 1, 1, 1, 10, 32'hA5A5);
      chk1("t5_rvalid1", rvalid1, 1'b0);
      chk32("t5_rdata1", rdata1, 32'd0);
      reset = 1'b0;
      drive(1, 0, 0, 9, 0, 1, 0, 0, 10, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Randomized traffic with slowly toggling lock requests.
      for (int i = 0; i < 600; i++) begin
         reset = ($urandom_range(0, 63) == 0);
         if ($urandom_range(0, 7) == 0) lk0 = !lk0;
         if ($urandom_range(0, 7) == 0) lk1 = !lk1;
         drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), lk0,
               32'($urandom_range(0, 15)), $urandom,
               $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), lk1,
               32'($urandom_range(0, 15)), $urandom);
      end
      reset = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
